ntt_req_arbiter: RTL

- Shares one 8-coefficient NTT/iNTT datapath between two requesters (req0, req1).
- Round-robin arbitration with an in-flight credit limit.
- Records the requester ID of every issued block in a tag FIFO; routes each datapath result back to the requester that issued it.
- Sits between the client controllers and the shared NTT/iNTT pipeline; the pipeline runs at fixed latency with no backpressure.

---
 rtl/ntt_pkg.sv | 28 ++
 rtl/ntt_req_arbiter_if.sv | 44 ++++
 rtl/ntt_tag_fifo.sv | 51 +++++
 rtl/ntt_req_arbiter.sv | 112 +++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared types and sizing for the NTT request arbiter slice.
package ntt_pkg;

    localparam int unsigned Q            = 3329;
    localparam int unsigned N_COEFF      = 8;
    localparam int unsigned COEFF_W      = 12;
    localparam int unsigned MAX_INFLIGHT = 8;
    localparam int unsigned CNT_W        = $clog2(MAX_INFLIGHT) + 1;

    typedef logic [COEFF_W-1:0]     coeff_t;
    typedef coeff_t [N_COEFF-1:0]   blk_t;
    typedef logic                   req_id_t;

    typedef enum logic {
        NTT_FWD = 1'b0,
        NTT_INV = 1'b1
    } ntt_mode_e;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

    // Payload handed to the shared datapath
    typedef struct packed {
        logic mode;
        blk_t coeffs;
    } dp_req_t;

endpackage

// File: rtl/ntt_req_arbiter_if.sv
// Handshake/bus bundle between two clients, the arbiter and the shared NTT datapath.
interface ntt_req_arbiter_if;
    import ntt_pkg::*;

    logic req0_valid;
    logic req0_ready;
    logic req0_mode;
    blk_t req0_coeffs;
    logic req1_valid;
    logic req1_ready;
    logic req1_mode;
    blk_t req1_coeffs;
    logic dp_valid_in;
    logic dp_mode;
    blk_t dp_coeffs;
    logic dp_valid_out;
    blk_t dp_coeffs_out;
    logic rsp0_valid;
    logic rsp1_valid;
    blk_t rsp_coeffs;
    logic busy;
    logic err_orphan;

    modport slave (
        input  req0_valid, req0_mode, req0_coeffs,
        input  req1_valid, req1_mode, req1_coeffs,
        input  dp_valid_out, dp_coeffs_out,
        output req0_ready, req1_ready,
        output dp_valid_in, dp_mode, dp_coeffs,
        output rsp0_valid, rsp1_valid, rsp_coeffs,
        output busy, err_orphan
    );

    modport master (
        output req0_valid, req0_mode, req0_coeffs,
        output req1_valid, req1_mode, req1_coeffs,
        output dp_valid_out, dp_coeffs_out,
        input  req0_ready, req1_ready,
        input  dp_valid_in, dp_mode, dp_coeffs,
        input  rsp0_valid, rsp1_valid, rsp_coeffs,
        input  busy, err_orphan
    );

endinterface

// File: rtl/ntt_tag_fifo.sv
// Synchronous FIFO; a pop frees its slot before a same-cycle push claims one.
module ntt_tag_fifo #(
    parameter  int unsigned WIDTH = 1,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PTR_W-1:0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic             pop_ok;
    logic             push_ok;

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (count_o == '0);
    assign full_o  = (count_o == PTR_W'(DEPTH));
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q[AW-1:0]] <= data_i;
                wr_ptr_q                <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/ntt_req_arbiter.sv
// Round-robin, credit-limited sharing of one NTT datapath between two clients,
// with tag tracking so each result returns to the client that issued it.
module ntt_req_arbiter
    import ntt_pkg::*;
(
    input  logic             clk,
    input  logic             r,
    ntt_req_arbiter_if.slave bus
);

    logic             grant0_c, grant1_c, grant_c;
    req_id_t          grant_id_c;
    req_id_t          tag_c;
    logic             tag_full_c, tag_empty_c;
    logic [CNT_W-1:0] inflight_c, inflight_d;
    logic             pop_c, orphan_c;

    req_id_t last_grant_q, last_grant_d;
    logic    dp_valid_q, dp_valid_d;
    dp_req_t dp_q, dp_d;
    logic    rsp0_q, rsp0_d, rsp1_q, rsp1_d;
    blk_t    rsp_coeffs_q, rsp_coeffs_d;
    logic    err_q, err_d;
    logic    busy_q, busy_d;

    // Grant decision uses the registered credit count only
    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        if (!r && !tag_full_c) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0_c = (last_grant_q == REQ1);
                grant1_c = (last_grant_q == REQ0);
            end else begin
                grant0_c = bus.req0_valid;
                grant1_c = bus.req1_valid;
            end
        end
    end

    assign grant_c        = grant0_c | grant1_c;
    assign grant_id_c     = grant1_c ? REQ1 : REQ0;
    assign bus.req0_ready = grant0_c;
    assign bus.req1_ready = grant1_c;
    assign pop_c          = bus.dp_valid_out && !tag_empty_c;
    assign orphan_c       = bus.dp_valid_out && tag_empty_c;

    // Tag occupancy doubles as the in-flight credit count
    ntt_tag_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (r),
        .push_i  (grant_c),
        .data_i  (grant_id_c),
        .pop_i   (bus.dp_valid_out),
        .data_o  (tag_c),
        .full_o  (tag_full_c),
        .empty_o (tag_empty_c),
        .count_o (inflight_c)
    );

    always_comb begin
        inflight_d   = inflight_c + CNT_W'(grant_c) - CNT_W'(pop_c);
        last_grant_d = grant_c ? grant_id_c : last_grant_q;
        dp_valid_d   = grant_c;
        dp_d         = dp_q;
        if (grant0_c) begin
            dp_d = '{mode: bus.req0_mode, coeffs: bus.req0_coeffs};
        end else if (grant1_c) begin
            dp_d = '{mode: bus.req1_mode, coeffs: bus.req1_coeffs};
        end
        rsp0_d       = pop_c && (tag_c == REQ0);
        rsp1_d       = pop_c && (tag_c == REQ1);
        rsp_coeffs_d = pop_c ? bus.dp_coeffs_out : rsp_coeffs_q;
        err_d        = err_q | orphan_c;
        busy_d       = (inflight_d != '0);
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            last_grant_q <= REQ1;
            dp_valid_q   <= 1'b0;
            dp_q         <= '0;
            rsp0_q       <= 1'b0;
            rsp1_q       <= 1'b0;
            rsp_coeffs_q <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            dp_valid_q   <= dp_valid_d;
            dp_q         <= dp_d;
            rsp0_q       <= rsp0_d;
            rsp1_q       <= rsp1_d;
            rsp_coeffs_q <= rsp_coeffs_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.dp_valid_in = dp_valid_q;
    assign bus.dp_mode     = dp_q.mode;
    assign bus.dp_coeffs   = dp_q.coeffs;
    assign bus.rsp0_valid  = rsp0_q;
    assign bus.rsp1_valid  = rsp1_q;
    assign bus.rsp_coeffs  = rsp_coeffs_q;
    assign bus.err_orphan  = err_q;
    assign bus.busy        = busy_q;

endmodule
